// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core and a
// debug/loader port. The core has priority. A pending debug access uses the
// first cycle with no core request, or takes one core cycle (core_stall)
// after MAX_WAIT blocked cycles.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_adr,
    input  logic [DW-1:0] core_wd,
    output logic [DW-1:0] core_rd,
    output logic          core_stall,
    // debug / loader side
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    // memory side
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RESP
    } state_t;

    // MAX_WAIT is limited to 1..255, so an 8-bit counter always suffices
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t        state;
    state_t        state_next;
    logic [7:0]    wait_cnt;
    logic [7:0]    wait_cnt_next;
    logic          held_we;
    logic [AW-1:0] held_adr;
    logic [DW-1:0] held_wd;
    logic          at_limit;
    logic          grant;
    logic          accept;

    // Arbitration decision for the current cycle
    always_comb begin
        at_limit   = (wait_cnt == WAIT_LIM);
        grant      = (state == PEND) && (!core_req || at_limit);
        core_stall = (state == PEND) && core_req && at_limit;
        // gated with rst_n so no request is advertised while reset is held
        dbg_ready  = rst_n && (state == IDLE);
        accept     = dbg_valid && dbg_ready;
        dbg_rvalid = (state == RESP);
    end

    // Next-state and wait counter logic
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = PEND;
                    wait_cnt_next = '0;
                end
            end
            PEND: begin
                if (grant) begin
                    state_next = RESP;
                end else if (!at_limit) begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory port mux: held debug access on a grant cycle, core otherwise
    always_comb begin
        if (grant) begin
            mem_we = held_we;
            mem_a  = held_adr;
            mem_wd = held_wd;
        end else begin
            mem_we = core_req && core_we;
            mem_a  = core_adr;
            mem_wd = core_wd;
        end
        // no memory write of any kind while reset is held
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // Core read data is a zero-latency pass-through of the memory
    always_comb begin
        core_rd = mem_rd;
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Holding registers capture the debug request on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_we  <= 1'b0;
            held_adr <= '0;
            held_wd  <= '0;
        end else if (accept) begin
            held_we  <= dbg_we;
            held_adr <= dbg_adr;
            held_wd  <= dbg_wd;
        end
    end

    // Debug read data latched on the grant cycle, held until next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata <= '0;
        end else if (grant) begin
            dbg_rdata <= held_we ? '0 : mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned MW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_adr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        dbg_valid;
    logic        dbg_ready;
    logic        dbg_we;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_wd;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_adr   (core_adr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_we     (dbg_we),
        .dbg_adr    (dbg_adr),
        .dbg_wd     (dbg_wd),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // data memory: combinational read, write on rising edge (256 words)
    logic [31:0] dmem [256];
    assign mem_rd = dmem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) dmem[mem_a[9:2]] <= mem_wd;

    // reference model state
    logic [31:0] ref_mem [256];
    bit          m_pend;
    bit          m_resp;
    int unsigned m_blocked;
    bit          m_we;
    logic [31:0] m_adr;
    logic [31:0] m_wd;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;
    int stalls_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive inputs, check outputs against model, advance model
    task automatic step(input bit rst, input bit creq, input bit cwe,
                        input logic [31:0] cadr, input logic [31:0] cwd,
                        input bit dv, input bit dwe,
                        input logic [31:0] dadr, input logic [31:0] dwd);
        bit          e_ready, e_stall, e_rvalid, e_we, grant, next_resp;
        logic [31:0] e_a, e_wd;
        @(negedge clk);
        rst_n = rst; core_req = creq; core_we = cwe; core_adr = cadr; core_wd = cwd;
        dbg_valid = dv; dbg_we = dwe; dbg_adr = dadr; dbg_wd = dwd;
        #1;
        if (!rst) begin
            m_pend = 0; m_resp = 0; m_rdata = '0; m_blocked = 0;
            e_ready = 0; e_stall = 0; e_rvalid = 0; grant = 0;
            e_we = 0; e_a = cadr; e_wd = cwd;
        end else begin
            e_rvalid = m_resp;
            e_ready  = !m_pend && !m_resp;
            grant    = m_pend && (!creq || m_blocked == MW);
            e_stall  = m_pend && creq && (m_blocked == MW);
            if (grant) begin
                e_we = m_we; e_a = m_adr; e_wd = m_wd;
            end else begin
                e_we = creq && cwe; e_a = cadr; e_wd = cwd;
            end
        end
        chk("dbg_ready",  {31'd0, dbg_ready},  {31'd0, e_ready});
        chk("core_stall", {31'd0, core_stall}, {31'd0, e_stall});
        chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e_rvalid});
        chk("dbg_rdata",  dbg_rdata, m_rdata);
        chk("mem_we",     {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_a",      mem_a,  e_a);
        chk("mem_wd",     mem_wd, e_wd);
        chk("core_rd",    core_rd, ref_mem[e_a[9:2]]);
        if (core_stall) stalls_seen++;
        if (rst) begin
            next_resp = 0;
            if (grant) begin
                m_rdata   = m_we ? 32'd0 : ref_mem[m_adr[9:2]];
                m_pend    = 0;
                next_resp = 1;
            end else if (m_pend && m_blocked < MW) begin
                m_blocked++;
            end
            if (e_we) ref_mem[e_a[9:2]] = e_wd;
            if (dv && e_ready) begin
                m_pend = 1; m_blocked = 0; m_we = dwe; m_adr = dadr; m_wd = dwd;
            end
            m_resp = next_resp;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_adr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        dmem[4]    = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;
        m_pend = 0; m_resp = 0; m_blocked = 0; m_rdata = '0;
        m_we = 0; m_adr = '0; m_wd = '0;
        rst_n = 0; core_req = 0; core_we = 0; core_adr = '0; core_wd = '0;
        dbg_valid = 0; dbg_we = 0; dbg_adr = '0; dbg_wd = '0;

        // reset held with a debug request offered
        step(0, 0, 0, 32'd0, 32'd0, 1, 0, 32'h40, 32'd0);
        step(0, 0, 0, 32'd0, 32'd0, 1, 0, 32'h40, 32'd0);
        chk("rst_ready", {31'd0, dbg_ready}, 32'd0);
        idle(1);
        chk("post_rst_ready", {31'd0, dbg_ready}, 32'd1);

        // debug write with core idle, then read it back
        step(1, 0, 0, 32'd0, 32'd0, 1, 1, 32'h40, 32'hDEAD_BEEF);
        idle(1);
        idle(2);
        chk("wr40_mem", dmem[16], 32'hDEAD_BEEF);
        step(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'h40, 32'd0);
        idle(3);
        chk("rd40", dbg_rdata, 32'hDEAD_BEEF);

        // core streams stores while a debug read waits: one forced stall
        stalls_seen = 0;
        step(1, 1, 1, 32'h100, 32'hC0DE_00FF, 1, 0, 32'h10, 32'd0);
        for (int i = 0; i < 12; i++)
            step(1, 1, 1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0, 0, 32'd0, 32'd0);
        idle(2);
        chk("stream_stalls", 32'(stalls_seen), 32'd1);
        chk("stall_store_dropped", dmem[72], 32'hA500_0048);
        chk("stream_rdata", dbg_rdata, 32'h1234_5678);

        // core busy 3 cycles then idle: no stall needed
        stalls_seen = 0;
        step(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'h40, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h200, 32'd0, 0, 0, 32'd0, 32'd0);
        idle(3);
        chk("busy3_stalls", 32'(stalls_seen), 32'd0);
        chk("busy3_rdata", dbg_rdata, 32'hDEAD_BEEF);

        // core load passes through while debug waits
        step(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'h44, 32'd0);
        step(1, 1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0);
        chk("core_rd_10", core_rd, 32'h1234_5678);
        idle(3);
        chk("rd44", dbg_rdata, 32'hA500_0011);

        // reset while a write to 0x80 is pending discards it
        step(1, 0, 0, 32'd0, 32'd0, 1, 1, 32'h80, 32'hBAD0_BAD0);
        step(1, 1, 0, 32'h200, 32'd0, 0, 0, 32'd0, 32'd0);
        step(0, 1, 0, 32'h200, 32'd0, 0, 0, 32'd0, 32'd0);
        idle(1);
        step(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'h80, 32'd0);
        idle(3);
        chk("rst_drop_80", dbg_rdata, 32'hA500_0020);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 rnd_adr(), $urandom(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 rnd_adr(), $urandom());
        end
        idle(MW + 4);

        for (int i = 0; i < 256; i++) chk("mem_final", dmem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle core and a debug/loader port. Debug accesses include program-data preload and memory peek/poke.
- Sits between riscvsingle and dmem in the top level. The core has priority. Debug transactions take free cycles, or force a one-cycle core stall after a bounded wait.
- Memory model: combinational read, write on the rising clock edge.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 8, max blocked cycles before a pending debug access steals a slot (1..255)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- core_req  input  1  core issues a load or store this cycle
- core_we  input  1  core store enable
- core_adr  input  AW  core address
- core_wd  input  DW  core write data
- core_rd  output  DW  core read data
- core_stall  output  1  core must hold PC/state this cycle; its access is not performed
- dbg_valid  input  1  debug request valid
- dbg_ready  output  1  arbiter can accept a debug request
- dbg_we  input  1  debug write enable
- dbg_adr  input  AW  debug address
- dbg_wd  input  DW  debug write data
- dbg_rvalid  output  1  one-cycle completion pulse
- dbg_rdata  output  DW  read data, valid with dbg_rvalid
- mem_we  output  1  to dmem WE
- mem_a  output  AW  to dmem A
- mem_wd  output  DW  to dmem WD
- mem_rd  input  DW  from dmem RD

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, wait_cnt=0, holding registers=0.
  - dbg_ready=0 while reset is asserted; dbg_ready=1 on the first cycle after release.
  - dbg_rvalid=0, dbg_rdata=0, core_stall=0.
- Reset mid-transaction discards any pending debug access. No memory write occurs for it.
- FSM states: IDLE, PEND, RESP.
- IDLE:
  - dbg_ready=1.
  - On dbg_valid&dbg_ready, capture we/adr/wd into holding registers, clear wait_cnt, go to PEND.
- PEND (dbg_ready=0):
  - Grant when core_req=0, or when wait_cnt==MAX_WAIT.
  - On a grant cycle, memory ports are driven from the holding registers.
  - On a grant cycle, dbg_rdata <= (held_we ? 0 : mem_rd) at the clock edge, and the FSM goes to RESP.
  - On a non-grant cycle (core_req=1 and wait_cnt<MAX_WAIT), wait_cnt increments and the FSM stays in PEND.
- core_stall = (state==PEND) & core_req & (wait_cnt==MAX_WAIT). It is combinational and lasts exactly one cycle per stolen slot.
  - During a stall, core_we is ignored; no core write occurs.
  - core_rd is don't-care during a stall.
- RESP:
  - dbg_rvalid=1 for exactly one cycle, then IDLE.
  - dbg_ready=0 in RESP. Back-to-back debug requests are therefore spaced by at least 3 cycles.
- Mux rule in all non-grant cycles: mem_we = core_req & core_we, mem_a = core_adr, mem_wd = core_wd.
- core_rd = mem_rd at all times; combinational pass-through, zero latency.
- Latency: accept edge k -> earliest grant cycle k+1 -> dbg_rvalid in cycle k+2.
- Worst-case latency: dbg_rvalid in cycle k+MAX_WAIT+2.
- wait_cnt saturates at MAX_WAIT and never wraps.
- dbg_rdata holds its value until the next completion.
- Same-address collision is resolved by serialization only; there is never a simultaneous write. Order is: core access in an earlier cycle, then debug access in the grant cycle.

Test Plan:
- Reset with dbg_valid=1 -> dbg_ready=0, no mem_we, dbg_rvalid=0; after release, dbg_ready=1, all outputs 0.
- Core idle: debug write adr=0x40 wd=0xDEADBEEF accepted at edge k -> mem_we=1, mem_a=0x40 in cycle k+1; dbg_rvalid pulses in k+2. A following debug read of 0x40 returns dbg_rdata=0xDEADBEEF.
- Core streaming stores every cycle with MAX_WAIT=8, debug read pending -> 8 cycles of core access with no stall, then core_stall=1 for exactly one cycle with mem_a=dbg_adr. dbg_rvalid follows the next cycle; the core store in the stall cycle is not written.
- Core busy for 3 cycles then idle -> debug granted in the 4th PEND cycle with core_stall never asserted; wait_cnt=3 at grant.
- Core load from 0x10 (preloaded 0x12345678) while a debug request is pending and not yet forced -> core_rd=0x12345678 combinationally in that cycle; the debug access is deferred.
- rst_n asserted while in PEND holding a write to 0x80 -> no write to 0x80 occurs (subsequent read returns the old value); FSM returns to IDLE.
